sseg_scan_mux: RTL
==================

Name: sseg_scan_mux

Overview:
Parametrised time-multiplexed seven-segment driver for the board display.
- Scans NUM_DIGITS common-anode digits with active-low segment and anode outputs.
- Adds per-digit decimal point, per-digit blanking, PWM brightness control and a frame-start strobe.
- Sits between datapath display registers (program counter, shifter values) and the board pins; the only block that drives SSEG_CA/SSEG_AN.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
REFRESH_DIV, 25000, clk cycles per digit slot (>= 2**DUTY_W)
DUTY_W, 4, width of brightness input

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
digits  in  4*NUM_DIGITS  hex nibbles; digits[4k+3:4k] is digit k, digit 0 leftmost
dp  in  NUM_DIGITS  decimal point request per digit, active high
blank  in  NUM_DIGITS  force digit k dark, active high
brightness  in  DUTY_W  on-time level; all-ones is full brightness
SSEG_CA  out  8  segments, active low, bit 7 = DP, bits 6:0 = g..a
SSEG_AN  out  NUM_DIGITS  anodes, active low; slot k drives SSEG_AN[NUM_DIGITS-1-k]
frame_start  out  1  one-cycle pulse at start of slot 0

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, slot=0
  - SSEG_AN all ones, SSEG_CA=8'hFF, frame_start=0
  - Outputs go dark immediately, including mid-scan.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, slot advances k -> k+1.
  - slot NUM_DIGITS-1 wraps to 0. There is no dead or idle slot.
- Input sampling: nibble, dp, blank and brightness for the new slot are captured when prescaler==0. Input changes mid-slot are not visible until the next slot.
- Outputs are registered, with a fixed one-cycle latency from prescaler/slot state to the pins.
- Font, active low:
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
  - dp=1 clears bit 7.
- Blanking: blank[k]=1 -> SSEG_CA=8'hFF and the slot's anode stays 1 for the whole slot. dp is ignored.
- Brightness:
  - on_time = ((brightness+1)*REFRESH_DIV) >> DUTY_W, computed at full width with no overflow.
  - The anode is 0 while prescaler < on_time, else 1.
  - SSEG_CA holds the glyph for the entire slot.
- Exactly one anode bit is low at any time, or none.
- frame_start is 1 for exactly the cycle whose outputs first show slot 0.

Optional Feature:
SSEG_LZ_SUPPRESS_EN
- Defined: leading-zero suppression.
  - Starting at digit 0, every digit whose nibble is 0 is treated as blanked, up to the first nonzero digit.
  - Digit NUM_DIGITS-1 is never suppressed.
  - Suppression is evaluated on the digits snapshot captured at slot 0 and held for the frame.
- Undefined: zeros display as "0". No extra logic is generated.

Decomposition:
- Package sseg_pkg holds:
  - SEG_BLANK=8'hFF and AN_OFF constant
  - 16-entry font constant array
  - function on_time(brightness, REFRESH_DIV, DUTY_W)
- One sub-module, sseg_hex_decoder: combinational nibble+dp -> 8-bit active-low pattern.
  - One instance is muxed by slot, not one per digit.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, DUTY_W=2 unless noted):
1. digits=16'hFA21 (digit0=1, digit1=2, digit2=A, digit3=F), brightness=3, dp=0, blank=0
   -> per 8-cycle slot: AN 0111/CA F9, AN 1011/CA A4, AN 1101/CA 88, AN 1110/CA 8E
   -> frame_start every 32 cycles.
2. Same digits, brightness=0 -> on_time=2: each anode low 2 of 8 cycles, CA stable for all 8.
3. blank=4'b0010 (digit1) -> slot 1 shows AN 1111, CA FF; other slots unchanged.
4. dp=4'b0100 (digit2), digit2=A -> slot 2 CA=08.
5. Assert rst at cycle 13 (mid slot 1) for 3 cycles -> AN 1111, CA FF in the same cycle. After release, the scan restarts at slot 0 with frame_start.
6. With SSEG_LZ_SUPPRESS_EN, digits=16'h0500 (digit0=0, digit1=0, digit2=5, digit3=0)
   -> slots 0 and 1 dark, slot 2 CA 92, slot 3 CA C0.
   -> Without the macro: C0, C0, 92, C0.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the seven-segment scan multiplexer.
package sseg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic       AN_OFF    = 1'b1;

  // Active-low glyphs, bit 7 = DP, bits 6:0 = g..a.
  localparam logic [7:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Anode on-time in prescaler ticks; 64-bit math so large dividers cannot overflow.
  function automatic logic [63:0] on_time(input logic [63:0] bright,
                                          input logic [63:0] refresh_div,
                                          input logic [63:0] duty_w);
    return ((bright + 64'd1) * refresh_div) >> duty_w;
  endfunction

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = FONT[nibble_i];
    if (dp_i) begin
      seg_o[7] = 1'b0;
    end
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with blanking, DP and PWM brightness.
// Define SSEG_LZ_SUPPRESS_EN to enable leading-zero suppression.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 25000,
  parameter int unsigned DUTY_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [DUTY_W-1:0]       brightness,
  output logic [7:0]              SSEG_CA,
  output logic [NUM_DIGITS-1:0]   SSEG_AN,
  output logic                    frame_start
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [3:0]            nib_q, nib_d;
  logic                  dp_q, dp_d;
  logic                  blank_q, blank_d;
  logic [DUTY_W-1:0]     bright_q, bright_d;
  logic [7:0]            ca_q, ca_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fs_q, fs_d;

  logic                  slot_start;
  logic                  blank_eff;
  logic [7:0]            glyph;
  logic [63:0]           on_full;
  logic [PW:0]           on_cnt;

  assign slot_start = (presc_q == '0);

  always_comb begin
    presc_d = presc_q + PW'(1);
    slot_d  = slot_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
    end
  end

  // The *_d values double as the slot's effective inputs: live at slot start, held after.
  always_comb begin
    nib_d    = nib_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    bright_d = bright_q;
    if (slot_start) begin
      nib_d    = '0;
      dp_d     = 1'b0;
      blank_d  = 1'b0;
      bright_d = brightness;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (slot_q == SW'(k)) begin
          nib_d   = digits[4*k +: 4];
          dp_d    = dp[k];
          blank_d = blank[k];
        end
      end
    end
  end

`ifdef SSEG_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_q, lz_d;
  logic                  lz_run;
  logic                  lz_sel;

  // Suppression mask is built once per frame from the slot-0 snapshot.
  always_comb begin
    lz_d   = lz_q;
    lz_run = 1'b1;
    if (slot_start && (slot_q == '0)) begin
      lz_d = '0;
      for (int k = 0; k < NUM_DIGITS - 1; k++) begin
        lz_run  = lz_run & (digits[4*k +: 4] == 4'h0);
        lz_d[k] = lz_run;
      end
    end
  end

  always_comb begin
    lz_sel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (slot_q == SW'(k)) begin
        lz_sel = lz_d[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lz_q <= '0;
    end else begin
      lz_q <= lz_d;
    end
  end

  assign blank_eff = blank_d | lz_sel;
`else
  assign blank_eff = blank_d;
`endif

  sseg_hex_decoder u_hex_decoder (
    .nibble_i (nib_d),
    .dp_i     (dp_d),
    .seg_o    (glyph)
  );

  assign on_full = on_time({{(64-DUTY_W){1'b0}}, bright_d}, 64'(REFRESH_DIV), 64'(DUTY_W));

  always_comb begin
    on_cnt = on_full[PW:0];
    if (|on_full[63:PW+1]) begin
      on_cnt = '1;
    end
  end

  always_comb begin
    fs_d = slot_start && (slot_q == '0);
    ca_d = SEG_BLANK;
    an_d = {NUM_DIGITS{AN_OFF}};
    if (!blank_eff) begin
      ca_d = glyph;
      if ({1'b0, presc_q} < on_cnt) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (slot_q == SW'(k)) begin
            an_d[NUM_DIGITS-1-k] = ~AN_OFF;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      slot_q   <= '0;
      nib_q    <= '0;
      dp_q     <= 1'b0;
      blank_q  <= 1'b0;
      bright_q <= '0;
      ca_q     <= SEG_BLANK;
      an_q     <= {NUM_DIGITS{AN_OFF}};
      fs_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      slot_q   <= slot_d;
      nib_q    <= nib_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      bright_q <= bright_d;
      ca_q     <= ca_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
    end
  end

  assign SSEG_CA     = ca_q;
  assign SSEG_AN     = an_q;
  assign frame_start = fs_q;

endmodule
